fb_line_reader: RTL and testbench
=================================

# fb_line_reader

Framebuffer scan-out engine for the poker display. It reads a 320x240, 12-bit RGB frame stored in external memory over a request/return read port and buffers it one source line ahead in two ping-pong line buffers. It emits pixel-doubled 640x480 Red/Green/Blue aligned to the `vga_controller` DrawX/DrawY sweep, so frames pre-rendered into memory can replace per-pixel combinational drawing in `top_screen`.

## Interface
Parameters:
- FB_BASE, 17'h0, word address of source pixel (0,0)
- SRC_W, 320, source pixels per line
- SRC_H, 240, source lines
- MAX_OUT, 4, maximum outstanding read requests (power of two, 1–8)

Ports:
- clk  in  1  pixel clock, 25 MHz; same clock as `vga_controller`
- reset  in  1  asynchronous, active-low
- DrawX  in  10  horizontal counter, 0–799
- DrawY  in  10  vertical counter, 0–524
- active_nblank  in  1  high in the 640x480 active region
- rd_req  out  1  read address valid
- rd_addr  out  17  word address = FB_BASE + s*SRC_W + x
- rd_ready  in  1  memory accepts the address when rd_req && rd_ready
- rd_valid  in  1  return data valid; data returns in order, latency ≥1
- rd_data  in  12  {R[11:8],G[7:4],B[3:0]}
- Red/Green/Blue  out  4 each  registered pixel colour
- busy  out  1  fetch in progress
- underrun  out  1  sticky error flag
- underrun_clr  in  1  synchronous clear of underrun

## Operation
- Source line s is stored in buffer s[0]. Display line y reads buffer (y>>1)[0] at index DrawX>>1.
- Fetch trigger: a single-cycle condition, DrawX==0 and (DrawY==523 or (DrawY even and DrawY≤476)).
  - Target source line: 0 if DrawY==523, otherwise DrawY/2+1.
  - Each fetch has a 1600-cycle window before its buffer is displayed.
- Fetch FSM:
  - IDLE: on trigger, latch s, clear x and the return index, set busy, and go to REQ.
  - REQ: hold rd_req=1 while x<SRC_W and outstanding<MAX_OUT. Increment x on each accepted handshake. When x==SRC_W, go to DRAIN.
  - DRAIN: wait until the return index reaches SRC_W, then go to IDLE and clear busy.
- Returns: each rd_valid writes rd_data to buffer[s[0]][return index], and the return index increments.
- Outstanding counter: +1 on handshake, −1 on rd_valid, both in the same cycle → unchanged. It never exceeds MAX_OUT.
- rd_req may drop only when a limit is reached. rd_addr is held stable while rd_req && !rd_ready.
- Underrun: set when a trigger arrives while busy. That trigger is dropped; the running fetch completes normally.
- Set/clear priority: set wins over underrun_clr in the same cycle.
- Output: when active_nblank, drive the buffered pixel; otherwise 0,0,0.
- The two buffers are uninitialised at reset, so frame 0 may show stale/X data until the first trigger at DrawY==523.

## Timing
- Reset values: rd_req=0, rd_addr=0, busy=0, underrun=0, Red=Green=Blue=0, FSM=IDLE, all counters 0.
- Pixel latency is 1 cycle: the output in cycle t+1 is the colour for DrawX/DrawY/active_nblank sampled at t.
  - This needs synchronous-read RAM plus an output register, so the buffer is addressed combinationally from DrawX.
  - The integrator delays hs/vs by one cycle.
- busy rises the cycle after the trigger. rd_req rises the cycle after the trigger.
- Best case (rd_ready=1, latency 1): busy falls SRC_W+2 cycles after the trigger.
- Reset mid-fetch aborts everything. The memory is required to be reset with the block; returns after reset are not tolerated.
- Buffer write and read never target the same buffer in the same cycle when the deadline is met.

## Structure
- `poker_types.svh` gains:
  - `fb_px_t` (12-bit packed struct r/g/b)
  - `fb_state_t` enum {FB_IDLE, FB_REQ, FB_DRAIN}
  - localparams FB_ACTIVE_W=640, FB_ACTIVE_H=480, FB_LINE_TOTAL=800, FB_FRAME_TOTAL=525
- Sub-module `fb_line_ram`: dual 320x12 simple-dual-port RAM with one write port and one synchronous read port, bank-select bit on each port, inferable as BRAM.

## Test plan
- Ideal memory (rd_ready=1, latency 1, data = address[11:0]), full frame → pixel (2x,2y) and (2x+1,2y+1) equal FB_BASE+y*320+x.
  - Check (0,0)=000, (639,479)=source (319,239), underrun=0.
- Backpressure: rd_ready toggling 1-of-3 cycles, latency 5, MAX_OUT=4.
  - Outstanding never exceeds 4, rd_addr is held stable under stall, and the image is identical to the ideal case.
- Underrun: rd_ready=0 from DrawY=10 for 2000 cycles.
  - underrun sets at the trigger of DrawY=12.
  - underrun_clr asserted in the same cycle → underrun stays 1.
  - A lone underrun_clr clears it next cycle.
- Blanking: DrawX 640–799 and DrawY 480–524 → Red=Green=Blue=0 one cycle later.
- Triggers: DrawY=523 DrawX=0 fetches s=0; DrawY=476 fetches s=239; DrawY=478 and all odd lines produce no fetch.
- Reset mid-fetch: reset low at return index 100 → all outputs at reset values immediately; the next trigger fetches the full line cleanly.

Source files
------------

// File: rtl/fb_line_reader_pkg.sv
// Shared types and frame geometry for the framebuffer scan-out engine.
package fb_line_reader_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } fb_px_t;

  typedef enum logic [1:0] {
    FB_IDLE,
    FB_REQ,
    FB_DRAIN
  } fb_state_t;

  localparam int unsigned FB_ACTIVE_W    = 640;
  localparam int unsigned FB_ACTIVE_H    = 480;
  localparam int unsigned FB_LINE_TOTAL  = 800;
  localparam int unsigned FB_FRAME_TOTAL = 525;

  // Fetch one source line ahead: every even active line up to 476, plus line 523 for source line 0.
  function automatic logic fb_fetch_trigger(input logic [9:0] x, input logic [9:0] y);
    return (x == '0) &&
           ((y == 10'(FB_FRAME_TOTAL - 2)) || (!y[0] && (y <= 10'(FB_ACTIVE_H - 4))));
  endfunction

endpackage

// File: rtl/fb_line_ram.sv
// Two line buffers in one simple-dual-port RAM: one write port, one synchronous read port.
module fb_line_ram
  import fb_line_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_idx,
  input  fb_px_t        wr_data,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_idx,
  output fb_px_t        rd_data
);

  localparam int unsigned MW = $clog2(2 * DEPTH);

  fb_px_t        mem [2*DEPTH];
  logic [MW-1:0] wr_a;
  logic [MW-1:0] rd_a;

  assign wr_a = (wr_bank ? MW'(DEPTH) : '0) + MW'(wr_idx);
  assign rd_a = (rd_bank ? MW'(DEPTH) : '0) + MW'(rd_idx);

  always_ff @(posedge clk) begin
    if (we)    mem[wr_a] <= wr_data;
    if (rd_en) rd_data   <= mem[rd_a];
  end

endmodule

// File: rtl/fb_line_reader.sv
// Framebuffer scan-out: fetches source lines one ahead into ping-pong buffers and
// emits a pixel-doubled 640x480 image one cycle behind the DrawX/DrawY sweep.
module fb_line_reader
  import fb_line_reader_pkg::*;
#(
  parameter logic [16:0] FB_BASE = 17'h0,
  parameter int unsigned SRC_W   = 320,
  parameter int unsigned SRC_H   = 240,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        active_nblank,
  output logic        rd_req,
  output logic [16:0] rd_addr,
  input  logic        rd_ready,
  input  logic        rd_valid,
  input  logic [11:0] rd_data,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic        busy,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam int unsigned IW = $clog2(SRC_W + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned SW = $clog2(SRC_H);

  fb_state_t      state;
  logic [SW-1:0]  src_line;
  logic [16:0]    line_base;
  logic [IW-1:0]  req_idx, ret_idx;
  logic [OW-1:0]  outstanding;

  logic           trig, hs;
  logic [SW-1:0]  trig_line;
  logic [IW-1:0]  req_idx_n, ret_idx_n;
  logic [OW-1:0]  out_n;
  logic [IW-1:0]  rd_idx;
  logic           disp_q;
  fb_px_t         px;

  function automatic logic [16:0] line_addr(input logic [SW-1:0] s);
    return FB_BASE + 17'(s) * 17'(SRC_W);
  endfunction

  assign trig      = fb_fetch_trigger(DrawX, DrawY);
  assign trig_line = (DrawY == 10'(FB_FRAME_TOTAL - 2)) ? '0 : SW'(DrawY[9:1] + 9'd1);

  always_comb begin
    hs        = rd_req & rd_ready;
    req_idx_n = req_idx + IW'(hs);
    ret_idx_n = ret_idx + IW'(rd_valid);
    out_n     = outstanding + OW'(hs) - OW'(rd_valid);
  end

  // rd_req/rd_addr are registered from next-cycle counts, so a stalled request keeps its address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FB_IDLE;
      src_line    <= '0;
      line_base   <= '0;
      req_idx     <= '0;
      ret_idx     <= '0;
      outstanding <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      outstanding <= out_n;
      ret_idx     <= ret_idx_n;
      if (trig && busy)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;

      unique case (state)
        FB_IDLE: begin
          if (trig) begin
            src_line  <= trig_line;
            line_base <= line_addr(trig_line);
            rd_addr   <= line_addr(trig_line);
            req_idx   <= '0;
            ret_idx   <= '0;
            rd_req    <= 1'b1;
            busy      <= 1'b1;
            state     <= FB_REQ;
          end
        end
        FB_REQ: begin
          req_idx <= req_idx_n;
          rd_addr <= line_base + 17'(req_idx_n);
          if (req_idx_n == IW'(SRC_W)) begin
            rd_req <= 1'b0;
            state  <= FB_DRAIN;
          end else begin
            rd_req <= (out_n < OW'(MAX_OUT));
          end
        end
        FB_DRAIN: begin
          if (ret_idx_n == IW'(SRC_W)) begin
            busy  <= 1'b0;
            state <= FB_IDLE;
          end
        end
        default: state <= FB_IDLE;
      endcase
    end
  end

  assign rd_idx = IW'(DrawX >> 1);

  fb_line_ram #(
    .DEPTH (SRC_W),
    .AW    (IW)
  ) u_ram (
    .clk     (clk),
    .we      (rd_valid && busy),
    .wr_bank (src_line[0]),
    .wr_idx  (ret_idx),
    .wr_data (rd_data),
    .rd_en   (active_nblank),
    .rd_bank (DrawY[1]),
    .rd_idx  (rd_idx),
    .rd_data (px)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) disp_q <= 1'b0;
    else        disp_q <= active_nblank;
  end

  assign Red   = disp_q ? px.r : '0;
  assign Green = disp_q ? px.g : '0;
  assign Blue  = disp_q ? px.b : '0;

endmodule

// File: tb/tb_fb_line_reader.sv
// Scoreboard bench for fb_line_reader: random sweep positions and memory timing
// against a line-level image model and an in-order read-return memory model.
module tb_fb_line_reader;

  localparam int          SRC_W   = 320;
  localparam int          MAX_OUT = 4;
  localparam logic [16:0] FB_BASE = 17'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  DrawX = 10'd700, DrawY = 10'd500;
  logic        active_nblank = 1'b0;
  logic        rd_req, rd_ready, rd_valid;
  logic [16:0] rd_addr;
  logic [11:0] rd_data;
  logic [3:0]  Red, Green, Blue;
  logic        busy, underrun;
  logic        underrun_clr = 1'b0;

  fb_line_reader #(
    .FB_BASE (FB_BASE),
    .SRC_W   (SRC_W),
    .SRC_H   (240),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk (clk), .reset (reset), .DrawX (DrawX), .DrawY (DrawY),
    .active_nblank (active_nblank), .rd_req (rd_req), .rd_addr (rd_addr),
    .rd_ready (rd_ready), .rd_valid (rd_valid), .rd_data (rd_data),
    .Red (Red), .Green (Green), .Blue (Blue), .busy (busy),
    .underrun (underrun), .underrun_clr (underrun_clr)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Image model: source pixel at word address a holds a[11:0].
  function automatic logic [11:0] src_px(input int s, input int x);
    logic [16:0] a;
    a = FB_BASE + 17'(s * SRC_W + x);
    return a[11:0];
  endfunction

  typedef struct { int due; logic [11:0] rgb; int x; int y; } pexp_t;
  pexp_t       pexp[$];
  logic [16:0] exp_addr[$];
  int          bank_line[2] = '{-1, -1};
  bit          fetching = 0;
  int          fetch_line = 0;
  bit          last_fetch = 0;

  // One cycle of sweep inputs; the model predicts the pixel and any fetch it starts.
  task automatic start(input int x, input int y, input bit act);
    pexp_t e;
    bit    trig;
    int    s;
    @(posedge clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); active_nblank = act;
    e.due = cyc + 1; e.x = x; e.y = y; e.rgb = '0;
    if (!act) pexp.push_back(e);
    else if (bank_line[(y / 2) % 2] == y / 2) begin
      e.rgb = src_px(y / 2, x / 2);
      pexp.push_back(e);
    end
    trig = (x == 0) && (y == 523 || (y % 2 == 0 && y <= 476));
    last_fetch = 0;
    if (trig && !fetching) begin
      s = (y == 523) ? 0 : y / 2 + 1;
      fetching = 1; fetch_line = s; last_fetch = 1;
      bank_line[s % 2] = -1;
      for (int i = 0; i < SRC_W; i++) exp_addr.push_back(FB_BASE + 17'(s * SRC_W + i));
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      start(700, 500, 0);
      n++;
    end while (busy === 1'b1 && n < 20000);
    check("fetch_done", {31'd0, busy}, 0);
    if (fetching) begin
      bank_line[fetch_line % 2] = fetch_line;
      fetching = 0;
    end
    check("addr_all_issued", exp_addr.size(), 0);
  endtask

  task automatic fetch(input int y, input int exp_lat);
    int n;
    bit f;
    start(0, y, 0);
    f = last_fetch;
    start(700, 500, 0);
    check($sformatf("busy_rise_y%0d", y), {31'd0, busy}, {31'd0, f});
    check($sformatf("rd_req_rise_y%0d", y), {31'd0, rd_req}, {31'd0, f});
    wait_idle(n);
    if (f && exp_lat > 0) check($sformatf("busy_fall_y%0d", y), n + 1, exp_lat);
  endtask

  task automatic pixels(input int y0, input int cnt);
    for (int k = 0; k < cnt; k++) start($urandom_range(1, 639), y0 + $urandom_range(0, 1), 1);
  endtask

  // Memory model: in-order returns, per-mode ready pattern, protocol checks.
  typedef struct { int due; logic [16:0] a; } ret_t;
  ret_t        rq[$];
  int          mem_mode = 0, lat = 1, ret_cnt = 0;
  bit          prev_stall = 0;
  logic [16:0] prev_addr = '0;

  initial begin
    ret_t r;
    rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rq.delete(); rd_valid = 1'b0; rd_ready = 1'b0; prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        check("rd_req_held", {31'd0, rd_req}, 1);
        check("rd_addr_held", {15'd0, rd_addr}, {15'd0, prev_addr});
      end
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        rd_valid = 1'b1; rd_data = r.a[11:0]; ret_cnt++;
      end else begin
        rd_valid = 1'b0; rd_data = 12'($urandom);
      end
      case (mem_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 3 == 0);
        2:       rd_ready = 1'b0;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (rd_req === 1'b1 && rd_ready) begin
        r.a = rd_addr;
        r.due = cyc + ((mem_mode == 3) ? $urandom_range(1, 6) : lat);
        rq.push_back(r);
        if (exp_addr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_addr_unexpected: got 0x%0h, want no request (cycle %0d)", rd_addr, cyc);
        end else check("rd_addr", {15'd0, rd_addr}, {15'd0, exp_addr.pop_front()});
        check("outstanding_le_max", {31'd0, rq.size() > MAX_OUT}, 0);
      end
      prev_stall = (rd_req === 1'b1) && !rd_ready;
      prev_addr  = rd_addr;
    end
  end

  // Pixel monitor: compares the registered colour against the queued expectation.
  initial begin
    pexp_t e;
    forever begin
      @(negedge clk);
      while (pexp.size() > 0 && pexp[0].due <= cyc) begin
        e = pexp.pop_front();
        check($sformatf("pixel(%0d,%0d)", e.x, e.y), {20'd0, Red, Green, Blue}, {20'd0, e.rgb});
      end
    end
  end

  initial begin
    #(40 * 100000);
    n_fail++;
    $display("FAIL global_timeout: got no end of test, want end within 100000 cycles");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_req", {31'd0, rd_req}, 0);
    check("reset_rd_addr", {15'd0, rd_addr}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_underrun", {31'd0, underrun}, 0);
    check("reset_rgb", {20'd0, Red, Green, Blue}, 0);
    @(negedge clk) reset = 1'b1;

    mem_mode = 0; lat = 1;
    fetch(523, SRC_W + 2);
    fetch(0, SRC_W + 2);
    start(0, 0, 1);
    wait_idle(n);
    pixels(0, 150);
    pixels(2, 60);
    check("underrun_after_ideal", {31'd0, underrun}, 0);

    fetch(478, 0);
    fetch(3, 0);
    fetch(1, 0);
    fetch(476, SRC_W + 2);
    start(639, 479, 1);
    pixels(478, 60);
    pixels(0, 30);

    for (int k = 0; k < 100; k++) start($urandom_range(640, 799), $urandom_range(0, 524), 0);
    for (int k = 0; k < 100; k++) start($urandom_range(1, 799), $urandom_range(480, 524), 0);

    mem_mode = 1; lat = 5;
    fetch(4, 0);
    pixels(6, 80);
    fetch(523, 0);
    pixels(0, 80);

    mem_mode = 3;
    fetch(8, 0);
    pixels(10, 80);

    mem_mode = 2;
    start(0, 10, 0);
    for (int i = 0; i < 1599; i++) start(700, 500, 0);
    check("underrun_before_late_trigger", {31'd0, underrun}, 0);
    check("busy_stalled", {31'd0, busy}, 1);
    start(0, 12, 0);
    underrun_clr = 1'b1;
    start(700, 500, 0);
    underrun_clr = 1'b0;
    check("underrun_set_wins", {31'd0, underrun}, 1);
    start(700, 500, 0);
    check("underrun_sticky", {31'd0, underrun}, 1);
    underrun_clr = 1'b1;
    start(700, 500, 0);
    underrun_clr = 1'b0;
    check("underrun_cleared", {31'd0, underrun}, 0);
    for (int i = 0; i < 396; i++) start(700, 500, 0);
    check("busy_through_stall", {31'd0, busy}, 1);
    mem_mode = 0; lat = 1;
    wait_idle(n);
    pixels(12, 60);

    ret_cnt = 0;
    start(0, 14, 0);
    for (int k = 0; k < 1000 && ret_cnt < 100; k++) start(700, 500, 0);
    check("reached_return_100", {31'd0, ret_cnt >= 100}, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    exp_addr.delete(); fetching = 0; bank_line[0] = -1;
    #1;
    check("midreset_rd_req", {31'd0, rd_req}, 0);
    check("midreset_rd_addr", {15'd0, rd_addr}, 0);
    check("midreset_busy", {31'd0, busy}, 0);
    check("midreset_underrun", {31'd0, underrun}, 0);
    check("midreset_rgb", {20'd0, Red, Green, Blue}, 0);
    repeat (3) start(700, 500, 0);
    @(negedge clk) reset = 1'b1;
    fetch(14, SRC_W + 2);
    pixels(16, 80);
    pixels(2, 30);

    repeat (3) start(700, 500, 0);
    @(negedge clk);
    @(negedge clk);
    check("pixel_queue_drained", pexp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
